// File: rtl/fthread_credit_pkg.sv
// Shared definitions for the outstanding-request credit gate.
//
// Contents:
//   - default values for the gate parameters
//   - stage_state_t : occupancy of the single registered request stage
//   - credit_cnt_width() : width of a per-tag counter able to hold
//                          0..max_outstanding
package fthread_credit_pkg;

    localparam int DEFAULT_NUMBER_OF_USERS     = 4;
    localparam int DEFAULT_USERS_BITS          = 2;
    localparam int DEFAULT_USER_LINE_IN_WIDTH  = 512;
    localparam int DEFAULT_USER_LINE_OUT_WIDTH = 512;
    localparam int DEFAULT_MAX_OUTSTANDING     = 8;

    typedef enum logic {
        STAGE_EMPTY = 1'b0,
        STAGE_FULL  = 1'b1
    } stage_state_t;

    // A counter must represent every value from 0 up to and including
    // max_outstanding, hence the +1.
    function automatic int credit_cnt_width(input int max_outstanding);
        return $clog2(max_outstanding + 1);
    endfunction

endpackage

// File: rtl/credit_counter.sv
// Per-tag outstanding-request counter.
//
// Counts requests charged to one tag (inc) against responses returned for
// it (dec). Saturates at both ends: it never exceeds MAX_OUTSTANDING and
// never wraps below zero. A response arriving while the count is zero is a
// protocol error; the count stays at zero and the sticky err flag is set.
//
// Ports:
//   clk       : clock
//   rst       : synchronous active-high reset; clears count and err
//   inc       : one request charged to this tag this cycle
//   dec       : one response returned for this tag this cycle
//   at_limit  : count has reached MAX_OUTSTANDING (no further credit)
//   zero_next : the count will be zero after this edge
//   err       : sticky, a response arrived with a zero count
module credit_counter
    import fthread_credit_pkg::*;
#(
    parameter int MAX_OUTSTANDING = DEFAULT_MAX_OUTSTANDING,
    parameter int CNT_W           = credit_cnt_width(MAX_OUTSTANDING)
) (
    input  logic clk,
    input  logic rst,
    input  logic inc,
    input  logic dec,
    output logic at_limit,
    output logic zero_next,
    output logic err
);

    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(MAX_OUTSTANDING);

    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_next;
    logic             err_set;

    always_comb begin
        cnt_next = cnt;
        err_set  = 1'b0;
        // A simultaneous charge and return cancel out and leave the count
        // untouched, including the zero case.
        if (inc && !dec) begin
            if (cnt != LIMIT) begin
                cnt_next = cnt + CNT_W'(1);
            end
        end else if (dec && !inc) begin
            if (cnt != '0) begin
                cnt_next = cnt - CNT_W'(1);
            end
        end
        if (dec && (cnt == '0)) begin
            err_set = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
            err <= 1'b0;
        end else begin
            cnt <= cnt_next;
            if (err_set) begin
                err <= 1'b1;
            end
        end
    end

    assign at_limit  = (cnt >= LIMIT);
    assign zero_next = (cnt_next == '0);

endmodule

// File: rtl/outstanding_credit_gate.sv
// Outstanding-request credit gate between a user regulator and memory.
//
// Each tag may have at most MAX_OUTSTANDING requests in flight. A credit is
// charged when a request is accepted on the input and returned when the
// matching response comes back from memory. Requests pass through a single
// registered stage toward memory; responses are registered once on the way
// back. The input stream is strictly in order: when the head request's tag
// has no credit, every tag behind it waits.
//
// Handshake: a transfer happens on a clock edge where valid and ready are
// both high; ready never looks at valid, and a producer holding valid with
// ready low must keep its payload stable (mem_tx_* obeys this). The
// response path (mem_rx_* -> out_rx_*) has no ready and cannot stall.
//
// Ports:
//   clk, rst        : clock, synchronous active-high reset
//   in_line/tag     : request payload and owner from the regulator
//   in_valid/ready  : request handshake
//   mem_tx_line/tag : request payload and owner toward memory
//   mem_tx_valid/rdy: memory request handshake
//   mem_rx_line/tag : response from memory, qualified by mem_rx_valid
//   out_rx_line/tag : registered response toward the regulator
//   out_rx_valid    : response valid, one cycle after mem_rx_valid
//   idle            : registered; all counters zero and request stage empty
//   credit_err      : sticky; a response arrived for a tag with no credit out
module outstanding_credit_gate
    import fthread_credit_pkg::*;
#(
    parameter int NUMBER_OF_USERS     = DEFAULT_NUMBER_OF_USERS,
    parameter int USERS_BITS          = DEFAULT_USERS_BITS,
    parameter int USER_LINE_IN_WIDTH  = DEFAULT_USER_LINE_IN_WIDTH,
    parameter int USER_LINE_OUT_WIDTH = DEFAULT_USER_LINE_OUT_WIDTH,
    parameter int MAX_OUTSTANDING     = DEFAULT_MAX_OUTSTANDING
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [USER_LINE_IN_WIDTH-1:0]  in_line,
    input  logic [USERS_BITS-1:0]          in_tag,
    input  logic                           in_valid,
    output logic                           in_ready,
    output logic [USER_LINE_IN_WIDTH-1:0]  mem_tx_line,
    output logic [USERS_BITS-1:0]          mem_tx_tag,
    output logic                           mem_tx_valid,
    input  logic                           mem_tx_ready,
    input  logic [USER_LINE_OUT_WIDTH-1:0] mem_rx_line,
    input  logic [USERS_BITS-1:0]          mem_rx_tag,
    input  logic                           mem_rx_valid,
    output logic [USER_LINE_OUT_WIDTH-1:0] out_rx_line,
    output logic [USERS_BITS-1:0]          out_rx_tag,
    output logic                           out_rx_valid,
    output logic                           idle,
    output logic                           credit_err
);

    localparam int CNT_W = credit_cnt_width(MAX_OUTSTANDING);

    stage_state_t stage_state;
    stage_state_t stage_next;

    logic                       accept;
    logic                       tag_at_limit;
    logic [NUMBER_OF_USERS-1:0] inc_vec;
    logic [NUMBER_OF_USERS-1:0] dec_vec;
    logic [NUMBER_OF_USERS-1:0] at_limit_vec;
    logic [NUMBER_OF_USERS-1:0] zero_next_vec;
    logic [NUMBER_OF_USERS-1:0] err_vec;

    // ------------------------------------------------------------------
    // Credit lookup for the head request. A tag value with no counter
    // behind it is never granted, so no request can leave untracked.
    // ------------------------------------------------------------------
    always_comb begin
        tag_at_limit = 1'b1;
        for (int i = 0; i < NUMBER_OF_USERS; i++) begin
            if (in_tag == USERS_BITS'(i)) begin
                tag_at_limit = at_limit_vec[i];
            end
        end
    end

    // The stage can take a new request when it is empty, or when memory is
    // draining it this very cycle (back-to-back replacement, no bubble).
    assign in_ready = !rst
                   && ((stage_state == STAGE_EMPTY) || mem_tx_ready)
                   && !tag_at_limit;

    assign accept = in_valid && in_ready;

    // ------------------------------------------------------------------
    // Per-tag credit counters. Credit is charged at acceptance, not at the
    // memory handoff, so a request parked in the stage already holds one.
    // ------------------------------------------------------------------
    for (genvar g = 0; g < NUMBER_OF_USERS; g++) begin : g_credit
        assign inc_vec[g] = accept && (in_tag == USERS_BITS'(g));
        assign dec_vec[g] = mem_rx_valid && (mem_rx_tag == USERS_BITS'(g));

        credit_counter #(
            .MAX_OUTSTANDING (MAX_OUTSTANDING),
            .CNT_W           (CNT_W)
        ) u_counter (
            .clk       (clk),
            .rst       (rst),
            .inc       (inc_vec[g]),
            .dec       (dec_vec[g]),
            .at_limit  (at_limit_vec[g]),
            .zero_next (zero_next_vec[g]),
            .err       (err_vec[g])
        );
    end

    // ------------------------------------------------------------------
    // Request stage occupancy
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            stage_state <= STAGE_EMPTY;
        end else begin
            stage_state <= stage_next;
        end
    end

    always_comb begin
        stage_next = stage_state;
        case (stage_state)
            STAGE_EMPTY: begin
                if (accept) begin
                    stage_next = STAGE_FULL;
                end
            end
            STAGE_FULL: begin
                if (accept) begin
                    stage_next = STAGE_FULL;
                end else if (mem_tx_ready) begin
                    stage_next = STAGE_EMPTY;
                end
            end
            default: stage_next = STAGE_EMPTY;
        endcase
    end

    assign mem_tx_valid = (stage_state == STAGE_FULL);

    // Payload only loads on acceptance, which keeps it frozen through any
    // memory stall (acceptance is impossible while full and not ready).
    always_ff @(posedge clk) begin
        if (rst) begin
            mem_tx_line <= '0;
            mem_tx_tag  <= '0;
        end else if (accept) begin
            mem_tx_line <= in_line;
            mem_tx_tag  <= in_tag;
        end
    end

    // ------------------------------------------------------------------
    // Response forwarding: one register stage, forwarded even on a
    // credit error so the regulator still sees the data.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            out_rx_valid <= 1'b0;
            out_rx_line  <= '0;
            out_rx_tag   <= '0;
        end else begin
            out_rx_valid <= mem_rx_valid;
            if (mem_rx_valid) begin
                out_rx_line <= mem_rx_line;
                out_rx_tag  <= mem_rx_tag;
            end
        end
    end

    // idle is registered from next-state values so it describes the same
    // cycle as the counters and stage it summarises.
    always_ff @(posedge clk) begin
        if (rst) begin
            idle <= 1'b1;
        end else begin
            idle <= (&zero_next_vec) && (stage_next == STAGE_EMPTY);
        end
    end

    assign credit_err = |err_vec;

endmodule
